// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//   Bit-serial adder/subtractor. Operands are accepted over a valid/ready
//   handshake, processed LSB first through a single full-adder cell with a
//   registered carry (one bit per clock), and the result is returned over a
//   second valid/ready handshake. Subtraction is a + ~b + (cin ^ 1), so cin
//   acts as a borrow-in and cout = 1 means "no borrow".
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request
//   in_ready   operands can be accepted (IDLE only)
//   a, b       WIDTH-bit operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   sum        WIDTH-bit result, held until the next DONE entry
//   cout       carry out of the MSB
//   ovf        two's-complement overflow
//   busy       high in BUSY or DONE
// -----------------------------------------------------------------------------
module serial_add_sub #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               bit_s, bit_c, last_bit;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  assign bit_s    = fa_sum(a_sh_q[0], b_sh_q[0], carry_q);
  assign bit_c    = fa_carry(a_sh_q[0], b_sh_q[0], carry_q);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic; in_ready is only high in IDLE, so in_valid alone
  // qualifies an accept there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Datapath next-state: operand latch on accept, one serial bit per BUSY edge
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        acc_d   = {bit_s, acc_q[WIDTH-1:1]};
        carry_d = bit_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // On the MSB, carry_q is the carry into the MSB and bit_c the
          // carry out; their difference flags signed overflow.
          sum_d  = {bit_s, acc_q[WIDTH-1:1]};
          cout_d = bit_c;
          ovf_d  = bit_c ^ carry_q;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8;
  logic [7:0] a8, b8, sum8;
  logic       cout8, ovf8, busy8;

  // WIDTH=2 instance
  logic       in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2;
  logic [1:0] a2, b2, sum2;
  logic       cout2, ovf2, busy2;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
  );

  serial_add_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(out_valid2),
    .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2), .busy(busy2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operand set on dut8 and wait for DONE; leaves out_ready low.
  task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic sb, input string tag);
    int  lat;
    bit  got;
    @(negedge clk);
    check({tag, " in_ready before accept"}, in_ready8, 1);
    a8 = a; b8 = b; cin8 = ci; sub8 = sb; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    check({tag, " in_ready after accept"}, in_ready8, 0);
    check({tag, " busy after accept"}, busy8, 1);
    lat = 0;
    got = 0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid8) got = 1;
    end
    check({tag, " latency"}, lat, 8);
  endtask

  task automatic release8(input string tag);
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
    check({tag, " out_valid after consume"}, out_valid8, 0);
    check({tag, " in_ready after consume"}, in_ready8, 1);
  endtask

  // Full WIDTH=2 transaction, consumed immediately.
  task automatic do2(input logic [1:0] a, input logic [1:0] b, input logic ci,
                     input logic sb, output logic [1:0] s, output logic co,
                     output logic ov, output int lat);
    bit got;
    @(negedge clk);
    a2 = a; b2 = b; cin2 = ci; sub2 = sb; in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    lat = 0;
    got = 0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid2) got = 1;
    end
    s = sum2; co = cout2; ov = ovf2;
    @(negedge clk);
    out_ready2 = 1'b1;
    @(posedge clk);
    #1;
    out_ready2 = 1'b0;
  endtask

  // Reference arithmetic for WIDTH=2 using plain wide addition
  task automatic model2(input logic [1:0] a, input logic [1:0] b, input logic ci,
                        input logic sb, output logic [1:0] s, output logic co,
                        output logic ov);
    logic [1:0] bb;
    logic [2:0] full;
    bb   = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {2'b00, ci ^ sb};
    s    = full[1:0];
    co   = full[2];
    ov   = (a[1] == bb[1]) && (s[1] != a[1]);
  endtask

  initial begin
    vec_t vecs[8];
    logic [7:0] hold_sum;
    logic       hold_cout, hold_ovf;
    logic [1:0] s2, es2;
    logic       c2, ec2, o2, eo2;
    int         lat2;
    int         acc_cyc[$];
    int         cyc;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    rst_n = 1'b0;
    in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    in_valid2 = 0; out_ready2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0;
    #1;
    check("reset in_ready", in_ready8, 1);
    check("reset out_valid", out_valid8, 0);
    check("reset busy", busy8, 0);
    check("reset sum", sum8, 0);
    check("reset cout", cout8, 0);
    check("reset ovf", ovf8, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven arithmetic vectors
    for (int i = 0; i < 8; i++) begin
      do8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, $sformatf("vec%0d", i));
      check($sformatf("vec%0d sum", i), sum8, vecs[i].sum);
      check($sformatf("vec%0d cout", i), cout8, vecs[i].cout);
      check($sformatf("vec%0d ovf", i), ovf8, vecs[i].ovf);
      release8($sformatf("vec%0d", i));
    end

    // Backpressure: DONE held while inputs wiggle
    do8(8'h0F, 8'h01, 1'b0, 1'b0, "bp");
    hold_sum = sum8; hold_cout = cout8; hold_ovf = ovf8;
    check("bp sum", hold_sum, 8'h10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid8 = ~in_valid8;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("bp%0d out_valid", i), out_valid8, 1);
      check($sformatf("bp%0d in_ready", i), in_ready8, 0);
      check($sformatf("bp%0d sum", i), sum8, hold_sum);
      check($sformatf("bp%0d cout", i), cout8, hold_cout);
      check($sformatf("bp%0d ovf", i), ovf8, hold_ovf);
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    release8("bp");
    check("bp busy after consume", busy8, 0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; cin8 = 0; sub8 = 0; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", in_ready8, 1);
    check("midrst out_valid", out_valid8, 0);
    check("midrst busy", busy8, 0);
    check("midrst sum", sum8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do8(8'h12, 8'h34, 1'b0, 1'b0, "postrst");
    check("postrst sum", sum8, 8'h46);
    check("postrst cout", cout8, 0);
    release8("postrst");

    // Exhaustive WIDTH=2
    for (int v = 0; v < 64; v++) begin
      do2(v[1:0], v[3:2], v[4], v[5], s2, c2, o2, lat2);
      model2(v[1:0], v[3:2], v[4], v[5], es2, ec2, eo2);
      check($sformatf("w2 v%0d latency", v), lat2, 2);
      check($sformatf("w2 v%0d sum", v), s2, es2);
      check($sformatf("w2 v%0d cout", v), c2, ec2);
      check($sformatf("w2 v%0d ovf", v), o2, eo2);
    end

    // Throughput with both handshakes tied high
    @(negedge clk);
    a2 = 2'b01; b2 = 2'b10; cin2 = 0; sub2 = 0;
    in_valid2 = 1'b1; out_ready2 = 1'b1;
    for (cyc = 0; cyc < 24; cyc++) begin
      if (in_ready2) acc_cyc.push_back(cyc);
      @(negedge clk);
    end
    in_valid2 = 1'b0; out_ready2 = 1'b0;
    check("tput accept count", acc_cyc.size(), 6);
    for (int i = 1; i < acc_cyc.size(); i++)
      check($sformatf("tput gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised bit-serial adder/subtractor, the sequential successor to the combinational full-adder cell.
- Accepts two WIDTH-bit operands over a valid/ready handshake.
- Processes one bit per clock, LSB first, through a single full-adder cell with a registered carry.
- Returns sum, carry-out and signed-overflow over a second valid/ready handshake; intended for area-constrained datapaths where latency is acceptable.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: a+b+cin; 1: a-b-cin
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf  output  1  two's-complement overflow
- busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=1; out_valid=0; busy=0.
  - sum=0, cout=0, ovf=0.
  - Shift registers, carry and counter cleared.
  - Takes effect immediately, including mid-operation; the in-flight operation is discarded with no partial result.
- States: IDLE, BUSY, DONE. in_ready and busy are decoded from the registered state only.
- IDLE:
  - On an edge with in_valid&in_ready: latch a into shift reg A; latch (sub ? ~b : b) into shift reg B.
  - Carry reg = cin ^ sub; counter=0; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, each edge:
  - s = A[0]^B[0]^carry; c = majority(A[0],B[0],carry).
  - Shift A and B right one bit; shift s into the MSB of the internal sum register; carry=c; counter++.
  - On the edge where counter==WIDTH-1, go to DONE.
  - That same edge loads sum from the completed shift value, cout=c, ovf = c ^ (carry into the MSB).
- Latency: out_valid rises exactly WIDTH clock edges after the accept edge.
- DONE:
  - out_valid=1; sum/cout/ovf held stable.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
- Output hold: sum/cout/ovf keep their last value until the next DONE entry. They are never visible mid-computation; the internal shift register is separate from the output register.
- Backpressure: out_ready low holds DONE indefinitely. in_valid is ignored in BUSY and DONE; operands are sampled only at the accept edge.
- Throughput: one operation per WIDTH+2 cycles with in_valid and out_ready tied high. There is no DONE->BUSY bypass.
- Input changes on a/b/cin/sub after the accept edge have no effect.
- Arithmetic:
  - Modulo 2^WIDTH.
  - cout is the raw carry of a + (b^{sub}) + (cin^sub).
  - ovf uses signed interpretation of the inputs.
- No X propagation: all state registers are reset.

Test Plan:
- WIDTH=8, a=0x0F, b=0x01, cin=0, sub=0:
  - Expect sum=0x10, cout=0, ovf=0.
  - out_valid high exactly 8 edges after the accept edge.
  - in_ready low from the accept edge until out_valid is consumed.
- Add boundaries:
  - 0xFF+0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
  - 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
  - 0xFF+0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
- Subtract:
  - 0x05-0x07, cin=0 -> sum=0xFE, cout=0, ovf=0.
  - 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
  - 0x10-0x0F, cin=1 -> sum=0x00, cout=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE while toggling in_valid and the operands.
  - Expect sum/cout/ovf unchanged, in_ready=0, no new accept.
  - Raise out_ready -> IDLE next edge, in_ready=1.
- Reset mid-op:
  - Assert rst_n=0 asynchronously after 3 BUSY cycles.
  - Expect immediate in_ready=1, out_valid=0, busy=0, sum=0.
  - Release and run 0x12+0x34 -> sum=0x46, cout=0.
- Exhaustive/throughput:
  - WIDTH=2: all 64 combinations of (a,b,cin,sub) checked against a behavioural model.
  - in_valid and out_ready tied high: consecutive accepts exactly 4 cycles apart.
